hs_unit_reset_seq: RTL

HS_UNIT_RESET_SEQ -- requirements
Module: hs_unit_reset_seq

---
 rtl/hs_unit_reset_seq_pkg.sv | 23 ++
 rtl/hs_unit_reset_seq_timer.sv | 30 +++
 rtl/hs_unit_reset_seq.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/hs_unit_reset_seq_pkg.sv
// Shared types and helpers for the staged reset sequencer.
package hs_pkg_reset_seq;

  // Sequencer states; values are fixed so they read the same in any netlist.
  typedef enum logic [2:0] {
    HOLD       = 3'd0,
    WAIT_READY = 3'd1,
    GAP        = 3'd2,
    DONE       = 3'd3,
    ERROR      = 3'd4
  } state_t;

  // Width of the shared down-counter: enough bits for the largest of the
  // three cycle parameters, plus one bit of headroom.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/hs_unit_reset_seq_timer.sv
// Loadable down-counter with a zero flag. A load always wins over a
// decrement, and a decrement at zero is ignored so the count never wraps.
module hs_unit_reset_seq_timer #(
  parameter int            CW        = 8,
  parameter logic [CW-1:0] RESET_VAL = '0
) (
  input  logic          clk,
  input  logic          areset,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  input  logic          dec,
  output logic          zero
);

  logic [CW-1:0] count_reg;

  // Count register: load, or decrement while non-zero.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      count_reg <= RESET_VAL;
    end else if (load) begin
      count_reg <= load_val;
    end else if (dec && (count_reg != '0)) begin
      count_reg <= count_reg - 1'b1;
    end
  end

  assign zero = (count_reg == '0);

endmodule

// File: rtl/hs_unit_reset_seq.sv
// Staged reset sequencer: holds every downstream reset for a stretch period,
// then releases the stages one by one, waiting for each stage's ready ack and
// inserting a gap before the next release. A missing ack latches an error.
module hs_unit_reset_seq
  import hs_pkg_reset_seq::*;
#(
  parameter int NUM_STAGES     = 4,
  parameter int STRETCH_CYCLES = 16,
  parameter int GAP_CYCLES     = 8,
  parameter int TIMEOUT_CYCLES = 1024,
  localparam int IDX_W         = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1
) (
  input  logic                  clk,
  input  logic                  areset,
  input  logic                  soft_reset_req,
  input  logic [NUM_STAGES-1:0] stage_ready,
  output logic [NUM_STAGES-1:0] rst_out,
  output logic                  seq_done,
  output logic                  seq_error,
  output logic [IDX_W-1:0]      error_stage
);

  localparam int            CW           = cnt_width(STRETCH_CYCLES, GAP_CYCLES, TIMEOUT_CYCLES);
  localparam logic [CW-1:0] STRETCH_LOAD = CW'(STRETCH_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LOAD     = CW'(GAP_CYCLES - 1);
  localparam logic [CW-1:0] TIMEOUT_LOAD = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_STAGES - 1);

  state_t                  state_reg, state_next;
  logic [IDX_W-1:0]        k_reg, k_next, k_inc;
  logic [NUM_STAGES-1:0]   rst_out_reg, rst_out_next;
  logic                    done_reg, done_next;
  logic                    error_reg, error_next;
  logic [IDX_W-1:0]        error_stage_reg, error_stage_next;

  logic                    tmr_load;
  logic [CW-1:0]           tmr_val;
  logic                    tmr_dec;
  logic                    tmr_zero;

  // One counter serves the stretch hold, the ready timeout and the gap.
  hs_unit_reset_seq_timer #(
    .CW       (CW),
    .RESET_VAL(STRETCH_LOAD)
  ) u_timer (
    .clk     (clk),
    .areset  (areset),
    .load    (tmr_load),
    .load_val(tmr_val),
    .dec     (tmr_dec),
    .zero    (tmr_zero)
  );

  assign k_inc = k_reg + 1'b1;

  // Next-state logic; a soft restart overrides every other transition.
  always_comb begin
    state_next       = state_reg;
    k_next           = k_reg;
    rst_out_next     = rst_out_reg;
    done_next        = done_reg;
    error_next       = error_reg;
    error_stage_next = error_stage_reg;
    tmr_load         = 1'b0;
    tmr_val          = '0;
    tmr_dec          = 1'b0;

    if (soft_reset_req) begin
      state_next       = HOLD;
      k_next           = '0;
      rst_out_next     = '1;
      done_next        = 1'b0;
      error_next       = 1'b0;
      error_stage_next = '0;
      tmr_load         = 1'b1;
      tmr_val          = STRETCH_LOAD;
    end else begin
      case (state_reg)
        HOLD: begin
          if (tmr_zero) begin
            state_next      = WAIT_READY;
            k_next          = '0;
            rst_out_next[0] = 1'b0;
            tmr_load        = 1'b1;
            tmr_val         = TIMEOUT_LOAD;
          end else begin
            tmr_dec = 1'b1;
          end
        end
        WAIT_READY: begin
          // Ready is checked first so an ack on the timeout edge still counts.
          if (stage_ready[k_reg]) begin
            if (k_reg == LAST_IDX) begin
              state_next = DONE;
              done_next  = 1'b1;
            end else begin
              state_next = GAP;
              tmr_load   = 1'b1;
              tmr_val    = GAP_LOAD;
            end
          end else if (tmr_zero) begin
            state_next       = ERROR;
            error_next       = 1'b1;
            error_stage_next = k_reg;
          end else begin
            tmr_dec = 1'b1;
          end
        end
        GAP: begin
          if (tmr_zero) begin
            state_next          = WAIT_READY;
            k_next              = k_inc;
            rst_out_next[k_inc] = 1'b0;
            tmr_load            = 1'b1;
            tmr_val             = TIMEOUT_LOAD;
          end else begin
            tmr_dec = 1'b1;
          end
        end
        DONE, ERROR: begin
          // Terminal until a restart.
        end
        default: begin
          state_next = HOLD;
        end
      endcase
    end
  end

  // State and output registers, forced to the hold state by areset.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state_reg       <= HOLD;
      k_reg           <= '0;
      rst_out_reg     <= '1;
      done_reg        <= 1'b0;
      error_reg       <= 1'b0;
      error_stage_reg <= '0;
    end else begin
      state_reg       <= state_next;
      k_reg           <= k_next;
      rst_out_reg     <= rst_out_next;
      done_reg        <= done_next;
      error_reg       <= error_next;
      error_stage_reg <= error_stage_next;
    end
  end

  assign rst_out     = rst_out_reg;
  assign seq_done    = done_reg;
  assign seq_error   = error_reg;
  assign error_stage = error_stage_reg;

endmodule
